// File: rtl/joy_serial_pkg.sv
// Shared types and helpers for the serial joystick receiver.
package joy_serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETUP,
    SHIFT_LO,
    SHIFT_HI,
    COMMIT
  } state_t;

  localparam int MAX_PLAYERS = 4;
  localparam int MAX_BITS    = 16;

  function automatic int min_poll_div(
    input int players,
    input int bits,
    input int clk_div
  );
    return 2 * clk_div * (players * bits + 1) + 2;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/joy_serial_phase.sv
// Half-phase timer: phase_last marks the final cycle of each
// CLK_DIV-long strobe phase while run is high.
module joy_serial_phase
  import joy_serial_pkg::*;
#(
  parameter int CLK_DIV = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic phase_last
);

  localparam int W = cnt_width(CLK_DIV);
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] cnt;

  assign phase_last = run && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || !run || phase_last)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/joy_serial_mp.sv
// Multi-player serial pad receiver for a 74HC165-style chain.
// Define JOY_SERIAL_DEBOUNCE_EN to accept only two identical frames.
module joy_serial_mp
  import joy_serial_pkg::*;
#(
  parameter int PLAYERS  = 2,
  parameter int BITS     = 16,
  parameter int CLK_DIV  = 24,
  parameter int POLL_DIV = 48000,
  parameter bit INVERT   = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    joy_clk,
  output logic                    joy_load,
  input  logic                    joy_data,
  output logic [PLAYERS*BITS-1:0] joystick,
  output logic                    frame_done
);

  localparam int N  = PLAYERS * BITS;
  localparam int KW = cnt_width(N);
  localparam int PW = cnt_width(POLL_DIV);

  localparam logic [KW-1:0] K_LAST   = KW'(N - 1);
  localparam logic [PW-1:0] P_WRAP   = PW'(POLL_DIV - 1);
  // Leaving IDLE one cycle early makes the registered joy_load
  // fall exactly on the poll terminal cycle.
  localparam logic [PW-1:0] P_LAUNCH = PW'(POLL_DIV - 2);

  if (PLAYERS < 1 || PLAYERS > MAX_PLAYERS ||
      BITS < 1 || BITS > MAX_BITS || CLK_DIV < 1 ||
      POLL_DIV < min_poll_div(PLAYERS, BITS, CLK_DIV)) begin : g_bad
    $error("joy_serial_mp: illegal parameter set");
  end

  state_t          state;
  state_t          state_nxt;
  logic [PW-1:0]   poll_cnt;
  logic [KW-1:0]   bit_idx;
  logic [N-1:0]    frame;
  logic            run;
  logic            phase_last;
  logic            sample;
  logic            commit;

  joy_serial_phase #(
    .CLK_DIV (CLK_DIV)
  ) u_phase (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .phase_last (phase_last)
  );

  always_ff @(posedge clk) begin
    if (reset || poll_cnt == P_WRAP)
      poll_cnt <= '0;
    else
      poll_cnt <= poll_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sample    = 1'b0;
    commit    = 1'b0;
    run       = 1'b0;
    unique case (state)
      IDLE: begin
        if (poll_cnt == P_LAUNCH)
          state_nxt = LOAD;
      end
      LOAD: begin
        run = 1'b1;
        if (phase_last)
          state_nxt = SETUP;
      end
      SETUP: begin
        run = 1'b1;
        if (phase_last)
          state_nxt = SHIFT_LO;
      end
      SHIFT_LO: begin
        run = 1'b1;
        if (phase_last) begin
          sample    = 1'b1;
          state_nxt = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        run = 1'b1;
        if (phase_last)
          state_nxt = (bit_idx == K_LAST) ? COMMIT : SHIFT_LO;
      end
      COMMIT: begin
        commit    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      joy_clk    <= 1'b0;
      joy_load   <= 1'b1;
      frame_done <= 1'b0;
      bit_idx    <= '0;
      frame      <= '0;
    end else begin
      joy_clk    <= (state_nxt == SHIFT_HI);
      joy_load   <= (state_nxt != LOAD);
      frame_done <= commit;
      if (state == IDLE)
        bit_idx <= '0;
      else if (state == SHIFT_HI && phase_last)
        bit_idx <= bit_idx + 1'b1;
      if (sample)
        frame[bit_idx] <= joy_data ^ INVERT;
    end
  end

`ifdef JOY_SERIAL_DEBOUNCE_EN
  logic [N-1:0] shadow;

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow   <= '0;
      joystick <= '0;
    end else if (commit) begin
      shadow <= frame;
      if (frame == shadow)
        joystick <= frame;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset)
      joystick <= '0;
    else if (commit)
      joystick <= frame;
  end
`endif

endmodule

// File: tb/tb_joy_serial_mp.sv
// Randomised bench: pad-chain model plus frame-level reference.
module tb_joy_serial_mp;

  localparam int PLAYERS   = 2;
  localparam int BITS      = 4;
  localparam int CLK_DIV   = 2;
  localparam int POLL_DIV  = 64;
  localparam bit INVERT    = 1'b1;
  localparam int N         = PLAYERS * BITS;
  localparam int FRAME_LEN = 2 * CLK_DIV * (N + 1) + 1;

`ifdef JOY_SERIAL_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
`else
  localparam bit DEB = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         joy_clk;
  logic         joy_load;
  logic         joy_data;
  logic [N-1:0] joystick;
  logic         frame_done;

  logic         joy_clk1;
  logic         joy_load1;
  logic [0:0]   joystick1;
  logic         frame_done1;

  always #5 clk = ~clk;

  joy_serial_mp #(
    .PLAYERS  (PLAYERS),
    .BITS     (BITS),
    .CLK_DIV  (CLK_DIV),
    .POLL_DIV (POLL_DIV),
    .INVERT   (INVERT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .joy_clk    (joy_clk),
    .joy_load   (joy_load),
    .joy_data   (joy_data),
    .joystick   (joystick),
    .frame_done (frame_done)
  );

  joy_serial_mp #(
    .PLAYERS  (1),
    .BITS     (1),
    .CLK_DIV  (1),
    .POLL_DIV (8),
    .INVERT   (1'b0)
  ) dut1 (
    .clk        (clk),
    .reset      (reset),
    .joy_clk    (joy_clk1),
    .joy_load   (joy_load1),
    .joy_data   (1'b1),
    .joystick   (joystick1),
    .frame_done (frame_done1)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Buttons shown after a frame, given the raw frame, the
  // previous raw frame and what was on display before.
  function automatic logic [7:0] model(
    input logic [7:0] raw,
    input logic [7:0] prev,
    input logic [7:0] held
  );
    if (DEB)
      return (raw == prev) ? raw : held;
    return raw;
  endfunction

  // Pad chain: parallel load on joy_load low, shift on joy_clk rise.
  logic [7:0] dir_pat [4] = '{8'hA5, 8'h12, 8'h34, 8'h34};
  logic [7:0] cur_pat = 8'h00;
  logic [7:0] chain   = 8'hFF;
  int         pat_idx = 0;

  always @(negedge joy_load) begin
    if (pat_idx < 4)
      cur_pat = dir_pat[pat_idx];
    else if ($urandom_range(0, 2) != 0)
      cur_pat = 8'($urandom);
    pat_idx++;
    chain = INVERT ? ~cur_pat : cur_pat;
  end

  always @(posedge joy_clk) chain = {INVERT, chain[7:1]};

  assign joy_data = chain[0];

  int cyc = 0;
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  logic       prev_load;
  logic       prev_clk;
  logic       prev_done;
  bit         first;
  int         load_start;
  int         load_len;
  int         edges;
  int         frames = 0;
  logic [7:0] exp_joy;
  logic [7:0] prev_raw;

  always @(negedge clk) begin
    if (reset) begin
      prev_load = 1'b1;
      prev_clk  = 1'b0;
      prev_done = 1'b0;
      first     = 1'b1;
      load_start = 0;
      load_len  = 0;
      edges     = 0;
      exp_joy   = '0;
      prev_raw  = '0;
    end else begin
      chk("excl", 32'(joy_clk & ~joy_load), 32'd0);
      if (!joy_load) begin
        if (prev_load) begin
          if (first)
            chk("first_load", 32'(cyc), 32'(POLL_DIV - 1));
          else
            chk("load_period", 32'(cyc - load_start), 32'(POLL_DIV));
          first      = 1'b0;
          load_start = cyc;
          edges      = 0;
          load_len   = 0;
        end
        load_len++;
      end else if (!prev_load) begin
        chk("load_len", 32'(load_len), 32'(CLK_DIV));
      end
      if (joy_clk && !prev_clk)
        edges++;
      if (frame_done) begin
        chk("done_pulse", 32'(prev_done), 32'd0);
        chk("frame_len", 32'(cyc - load_start), 32'(FRAME_LEN));
        chk("clk_edges", 32'(edges), 32'(N));
        exp_joy  = model(cur_pat, prev_raw, exp_joy);
        prev_raw = cur_pat;
        chk("joystick", 32'(joystick), 32'(exp_joy));
        frames++;
      end else begin
        chk("hold", 32'(joystick), 32'(exp_joy));
      end
      prev_load = joy_load;
      prev_clk  = joy_clk;
      prev_done = frame_done;
    end
  end

  logic       prev_load1;
  int         load_start1;
  logic [7:0] exp1;
  logic [7:0] prev_raw1;

  always @(negedge clk) begin
    if (reset) begin
      prev_load1  = 1'b1;
      load_start1 = 0;
      exp1        = '0;
      prev_raw1   = '0;
    end else begin
      if (!joy_load1 && prev_load1)
        load_start1 = cyc;
      if (frame_done1) begin
        chk("p1_len", 32'(cyc - load_start1), 32'd5);
        exp1      = model(8'd1, prev_raw1, exp1);
        prev_raw1 = 8'd1;
        chk("p1_joy", 32'(joystick1), 32'(exp1[0]));
      end
      prev_load1 = joy_load1;
    end
  end

  initial begin
    bit found;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_joy", 32'(joystick), 32'd0);
    chk("rst_load", 32'(joy_load), 32'd1);
    chk("rst_clk", 32'(joy_clk), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_joy1", 32'(joystick1), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 2000 && frames < 10; i++)
      @(posedge clk);
    if (frames < 10)
      chk("timeout_a", 32'(frames), 32'd10);

    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (edges == 4 && joy_clk) begin
        found = 1'b1;
        break;
      end
    end
    chk("find_hi3", 32'(found), 32'd1);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_joy", 32'(joystick), 32'd0);
    chk("mid_clk", 32'(joy_clk), 32'd0);
    chk("mid_load", 32'(joy_load), 32'd1);
    chk("mid_done", 32'(frame_done), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 2000 && frames < 20; i++)
      @(posedge clk);
    if (frames < 20)
      chk("timeout_b", 32'(frames), 32'd20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
